// File: rtl/l15_pkg.sv
// Shared encodings for the L1.5 responder: request/return types, access sizes,
// FSM states and helpers that decode a request into lane enables and error status.
package l15_pkg;

  localparam logic [5:0] RQ_LOAD  = 6'h00;
  localparam logic [5:0] RQ_STORE = 6'h01;

  localparam logic [3:0] RT_LOAD_RET = 4'h0;
  localparam logic [3:0] RT_ST_ACK   = 4'h4;
  localparam logic [3:0] RT_ERR_RET  = 4'hF;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } l15_state_e;

  // Unknown type, oversize or misaligned accesses are answered with ERR_RET.
  function automatic logic req_is_err(logic [5:0] rq, logic [2:0] sz, logic [1:0] off);
    logic err;
    err = 1'b0;
    if (rq != RQ_LOAD && rq != RQ_STORE) err = 1'b1;
    if (sz > SZ_WORD)                    err = 1'b1;
    if (sz == SZ_HALF && off[0])         err = 1'b1;
    if (sz == SZ_WORD && off != 2'd0)    err = 1'b1;
    return err;
  endfunction

  function automatic logic [3:0] byte_en(logic [2:0] sz, logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// Word-addressed backing store split into four byte lanes; synchronous
// byte-enabled write, combinational read. Contents are never reset.
module l15_resp_mem #(
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [3:0]                   be,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_WORDS];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/l15_responder.sv
// Single-outstanding L1.5 request responder: IDLE -> HDR -> WAIT -> RESP.
// Optional macro L15_RESP_RANDLAT_EN adds LFSR jitter (0..3 cycles) to the wait time.
module l15_responder
  import l15_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [5:0]  core_l15_rqtype,
  input  logic [2:0]  core_l15_size,
  input  logic [31:0] core_l15_address,
  input  logic [31:0] core_l15_data,
  input  logic        core_l15_val,
  output logic [31:0] l15_core_data_0,
  output logic [3:0]  l15_core_returntype,
  output logic        l15_core_val,
  output logic        l15_core_ack,
  output logic        l15_core_header_ack
);

  localparam int AW = $clog2(MEM_WORDS);

  l15_state_e  state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [4:0]  lat_load;
  logic [5:0]  rq_reg;
  logic [2:0]  size_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0] data_reg;
  logic        err;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        addr_unused;

  // Address bits above the store depth alias silently.
  assign addr_unused = ^core_l15_address[31:AW+2];

`ifdef L15_RESP_RANDLAT_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign lat_load = 5'(LATENCY) + {3'b000, lfsr_reg[1:0]};
`else
  assign lat_load = 5'(LATENCY);
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: if (core_l15_val) state_next = ST_HDR;
      ST_HDR: begin
        cnt_next   = lat_load;
        state_next = (lat_load == 5'd0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg <= 5'd1) begin
          cnt_next   = 5'd0;
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 5'd0;
      rq_reg    <= 6'd0;
      size_reg  <= 3'd0;
      addr_reg  <= '0;
      data_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_IDLE && core_l15_val) begin
        rq_reg   <= core_l15_rqtype;
        size_reg <= core_l15_size;
        addr_reg <= core_l15_address[AW+1:0];
        data_reg <= core_l15_data;
      end
    end
  end

  assign err       = req_is_err(rq_reg, size_reg, addr_reg[1:0]);
  assign mem_we    = (state_reg == ST_HDR) && (rq_reg == RQ_STORE) && !err;
  assign mem_be    = byte_en(size_reg, addr_reg[1:0]);
  assign mem_wdata = data_reg << {addr_reg[1:0], 3'b000};

  l15_resp_mem #(
    .MEM_WORDS(MEM_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (addr_reg[AW+1:2]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Outputs decode straight from registered state, so reset clears them immediately.
  always_comb begin
    l15_core_header_ack = (state_reg == ST_HDR);
    l15_core_val        = (state_reg == ST_RESP);
    l15_core_ack        = (state_reg == ST_RESP);
    l15_core_returntype = 4'h0;
    l15_core_data_0     = 32'd0;
    if (state_reg == ST_RESP) begin
      if (err) begin
        l15_core_returntype = RT_ERR_RET;
      end else if (rq_reg == RQ_LOAD) begin
        l15_core_returntype = RT_LOAD_RET;
        l15_core_data_0     = mem_rdata;
      end else begin
        l15_core_returntype = RT_ST_ACK;
      end
    end
  end

endmodule

// File: tb/tb_l15_responder.sv
// Directed self-checking bench for l15_responder (MEM_WORDS=256, LATENCY=2).
module tb_l15_responder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [5:0]  core_l15_rqtype = 6'd0;
  logic [2:0]  core_l15_size = 3'd0;
  logic [31:0] core_l15_address = 32'd0;
  logic [31:0] core_l15_data = 32'd0;
  logic        core_l15_val = 1'b0;
  logic [31:0] l15_core_data_0;
  logic [3:0]  l15_core_returntype;
  logic        l15_core_val;
  logic        l15_core_ack;
  logic        l15_core_header_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  l15_responder #(
    .MEM_WORDS(256),
    .LATENCY(2)
  ) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .core_l15_rqtype     (core_l15_rqtype),
    .core_l15_size       (core_l15_size),
    .core_l15_address    (core_l15_address),
    .core_l15_data       (core_l15_data),
    .core_l15_val        (core_l15_val),
    .l15_core_data_0     (l15_core_data_0),
    .l15_core_returntype (l15_core_returntype),
    .l15_core_val        (l15_core_val),
    .l15_core_ack        (l15_core_ack),
    .l15_core_header_ack (l15_core_header_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call just after a rising edge; request is captured at the next edge (cycle 0).
  task automatic do_req(input string tag, input logic [5:0] rq, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] exp_rt, input logic [31:0] exp_data);
    int hdr_cyc = -1;
    int resp_cyc = -1;
    logic [3:0]  rt = 4'h0;
    logic [31:0] d = 32'd0;
    logic        ak = 1'b0;
    logic        leak = 1'b0;
    core_l15_rqtype  = rq;
    core_l15_size    = sz;
    core_l15_address = addr;
    core_l15_data    = wdata;
    core_l15_val     = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (l15_core_header_ack && hdr_cyc < 0) begin
        hdr_cyc = c;
        core_l15_val = 1'b0;
      end
      if (l15_core_val) begin
        resp_cyc = c;
        rt = l15_core_returntype;
        d  = l15_core_data_0;
        ak = l15_core_ack;
        break;
      end else if (l15_core_data_0 != 32'd0 || l15_core_returntype != 4'h0 || l15_core_ack) begin
        leak = 1'b1;
      end
    end
    core_l15_val = 1'b0;
    chk($sformatf("%s.hdr_cycle", tag), 32'(hdr_cyc), 32'd1);
    chk($sformatf("%s.resp_cycle", tag), 32'(resp_cyc), 32'd4);
    chk($sformatf("%s.rettype", tag), {28'd0, rt}, {28'd0, exp_rt});
    chk($sformatf("%s.data", tag), d, exp_data);
    chk($sformatf("%s.ack", tag), {31'd0, ak}, 32'd1);
    chk($sformatf("%s.idle_outs_zero", tag), {31'd0, leak}, 32'd0);
    $display("[TB] %s rq=%h sz=%0d addr=%h wdata=%h -> rt=%h data=%h hdr@%0d resp@%0d",
             tag, rq, sz, addr, wdata, rt, d, hdr_cyc, resp_cyc);
  endtask

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int val_seen;
    repeat (2) @(negedge clk);
    chk("reset.val", {31'd0, l15_core_val}, 32'd0);
    chk("reset.ack", {31'd0, l15_core_ack}, 32'd0);
    chk("reset.hdr_ack", {31'd0, l15_core_header_ack}, 32'd0);
    chk("reset.rettype", {28'd0, l15_core_returntype}, 32'd0);
    chk("reset.data", l15_core_data_0, 32'd0);
    next_slot();
    nrst = 1'b1;

    next_slot(); do_req("st_word_10",  6'h00 + 6'h01, 3'd2, 32'h10, 32'hDEADBEEF, 4'h4, 32'h0);
    next_slot(); do_req("ld_word_10",  6'h00, 3'd2, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    next_slot(); do_req("st_byte_13",  6'h01, 3'd0, 32'h13, 32'h55, 4'h4, 32'h0);
    next_slot(); do_req("ld_after_b",  6'h00, 3'd2, 32'h10, 32'h0, 4'h0, 32'h55ADBEEF);
    next_slot(); do_req("ld_mis_12",   6'h00, 3'd2, 32'h12, 32'h0, 4'hF, 32'h0);
    next_slot(); do_req("st_mis_11",   6'h01, 3'd2, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0);
    next_slot(); do_req("st_hmis_11",  6'h01, 3'd1, 32'h11, 32'hFFFF, 4'hF, 32'h0);
    next_slot(); do_req("st_size3",    6'h01, 3'd3, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0);
    next_slot(); do_req("bad_rqtype",  6'h02, 3'd2, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0);
    next_slot(); do_req("ld_unchanged",6'h00, 3'd2, 32'h10, 32'h0, 4'h0, 32'h55ADBEEF);
    next_slot(); do_req("st_word_14",  6'h01, 3'd2, 32'h14, 32'h0, 4'h4, 32'h0);
    next_slot(); do_req("st_half_16",  6'h01, 3'd1, 32'h16, 32'hBEEF, 4'h4, 32'h0);
    next_slot(); do_req("ld_14_a",     6'h00, 3'd2, 32'h14, 32'h0, 4'h0, 32'hBEEF0000);
    next_slot(); do_req("st_half_14",  6'h01, 3'd1, 32'h14, 32'h1234, 4'h4, 32'h0);
    next_slot(); do_req("ld_14_b",     6'h00, 3'd2, 32'h14, 32'h0, 4'h0, 32'hBEEF1234);
    next_slot(); do_req("st_alias_410",6'h01, 3'd2, 32'h410, 32'h12345678, 4'h4, 32'h0);
    next_slot(); do_req("ld_alias_10", 6'h00, 3'd2, 32'h10, 32'h0, 4'h0, 32'h12345678);

    // Reset in the middle of a WAIT with the request still held.
    next_slot();
    core_l15_rqtype  = 6'h00;
    core_l15_size    = 3'd2;
    core_l15_address = 32'h10;
    core_l15_data    = 32'h0;
    core_l15_val     = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rst_wait.val", {31'd0, l15_core_val}, 32'd0);
    chk("rst_wait.ack", {31'd0, l15_core_ack}, 32'd0);
    chk("rst_wait.hdr_ack", {31'd0, l15_core_header_ack}, 32'd0);
    chk("rst_wait.outs", {l15_core_data_0[27:0], l15_core_returntype}, 32'd0);
    val_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (l15_core_val) val_seen++;
    end
    chk("rst_wait.no_val_pulse", 32'(val_seen), 32'd0);
    $display("[TB] rst_wait reset asserted during WAIT, val pulses seen=%0d", val_seen);
    next_slot();
    nrst = 1'b1;
    do_req("held_after_rst", 6'h00, 3'd2, 32'h10, 32'h0, 4'h0, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l15_responder.md
L15_RESPONDER -- requirements
Module: l15_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning word-addressed backing store depth (power of 2).
REQ-002 SHALL have parameter LATENCY, default 2, meaning WAIT cycles between header ack and response (range 0-15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port core_l15_rqtype  input  6  request type: LOAD=6'h00, STORE=6'h01.
REQ-006 SHALL have port core_l15_size  input  3  access size: 0=byte, 1=half, 2=word.
REQ-007 SHALL have port core_l15_address  input  32  byte address.
REQ-008 SHALL have port core_l15_data  input  32  store data, LSB-aligned.
REQ-009 SHALL have port core_l15_val  input  1  request valid; initiator holds all request fields until header ack.
REQ-010 SHALL have port l15_core_data_0  output  32  load return data.
REQ-011 SHALL have port l15_core_returntype  output  4  LOAD_RET=4'h0, ST_ACK=4'h4, ERR_RET=4'hF.
REQ-012 SHALL have port l15_core_val  output  1  response valid, one-cycle pulse.
REQ-013 SHALL have port l15_core_ack  output  1  response-accepted strobe, coincident with l15_core_val.
REQ-014 SHALL have port l15_core_header_ack  output  1  request-captured strobe, one-cycle pulse.

Function
REQ-015 SHALL implement FSM IDLE -> HDR -> WAIT -> RESP -> IDLE, one request in flight.
REQ-016 SHALL, in IDLE with core_l15_val=1, capture rqtype/size/address/data and go to HDR next cycle.
REQ-017 SHALL assert l15_core_header_ack for exactly the HDR cycle.
REQ-018 SHALL load the latency counter with LATENCY in HDR, decrement it in WAIT, and leave WAIT when it reaches 0; LATENCY=0 goes HDR -> RESP directly.
REQ-019 SHALL assert l15_core_val and l15_core_ack for exactly the RESP cycle, with returntype and data stable that cycle; data_0 and returntype SHALL be 0 outside RESP.
REQ-020 SHALL ignore core_l15_val outside IDLE; a held request is captured on the first IDLE cycle after RESP (back-to-back throughput one request per LATENCY+3 cycles).
REQ-021 SHALL index memory by address[log2(MEM_WORDS)+1:2], wrapping higher address bits silently.
REQ-022 SHALL, for LOAD, return the full aligned 32-bit word; core-side lane extraction is not this block's job.
REQ-023 SHALL, for STORE, shift LSB-aligned data to lane address[1:0] and write only enabled bytes (byte: 1 lane, half: 2 lanes, word: 4 lanes) during HDR; response returntype ST_ACK, data 0.
REQ-024 SHALL treat misalignment (half with address[0]=1, word with address[1:0]!=0), size>2 or rqtype not LOAD/STORE as error: no memory write, returntype ERR_RET, data 0, same timing.
REQ-025 SHALL make a LOAD immediately following a STORE to the same word return the stored value.

Reset
REQ-026 SHALL, on nrst=0, asynchronously force FSM to IDLE, counter to 0 and all outputs to 0; an in-flight request is dropped without response.
REQ-027 SHALL NOT reset memory contents; they are undefined after power-up unless written.

Configuration
REQ-028 SHALL, with L15_RESP_RANDLAT_EN defined, add a 16-bit LFSR (seed 16'hACE1 on reset, advanced every cycle) and load the counter with LATENCY + lfsr[1:0] in HDR.
REQ-029 SHALL, without L15_RESP_RANDLAT_EN, have no LFSR and fixed LATENCY.

Structure
REQ-030 SHALL take rqtype, returntype and size encodings from a shared package l15_pkg, together with the FSM state enum.
REQ-031 SHALL place the byte-enable RAM in sub-module l15_resp_mem (synchronous write, combinational read).

Verification
REQ-032 SHALL cover: STORE word 0xDEADBEEF @0x10, LATENCY=2 -> header_ack cycle 1, val/ack cycle 4, returntype 4'h4.
REQ-033 SHALL cover: then LOAD @0x10 -> data_0=0xDEADBEEF, returntype 4'h0.
REQ-034 SHALL cover: STORE byte 0x55 @0x13, then LOAD @0x10 -> 0x55ADBEEF.
REQ-035 SHALL cover: LOAD word @0x12 -> ERR_RET 4'hF, data 0, memory unchanged.
REQ-036 SHALL cover: nrst low during WAIT -> outputs 0 at once, no val pulse; held request afterwards served normally.
REQ-037 SHALL cover: address 0x410 (MEM_WORDS=256) -> aliases 0x010.
